// File: rtl/jump_decode_ras_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jump_decode_ras_pkg
// Description : Shared definitions for the multi-lane jump decoder: jump_type
//               encodings, opcode constants and the per-lane decode result.
// Config      : JDEC_RAS_EN (consumed by jump_decode_ras, not used here)
// Revision    : 1.0 - initial multi-lane release
// ============================================================================
package jump_decode_ras_pkg;

    localparam int CONST_WIDTH = 65;

    // jump_type encodings shared with the branch unit
    localparam logic [4:0] JT_UNCOND = 5'h10;
    localparam logic [4:0] JT_INDIR  = 5'h11;

    // Opcode byte values (instr[7:0])
    localparam logic [7:0] c_OPC_UNCOND  = 8'd181;
    localparam logic [7:0] c_OPC_GROUP   = 8'd182;
    localparam logic [3:0] c_OPC_COND_HI = 4'hA;

    // Sub-operation field instr[15:13] of the 182 group
    localparam logic [2:0] c_SUB_INDIR  = 3'd0;
    localparam logic [2:0] c_SUB_CALL_A = 3'd1;
    localparam logic [2:0] c_SUB_CALL_B = 3'd2;
    localparam logic [2:0] c_SUB_RET    = 3'd3;

    typedef enum logic [2:0] {
        JK_NONE   = 3'd0,
        JK_COND   = 3'd1,
        JK_UNCOND = 3'd2,
        JK_INDIR  = 3'd3,
        JK_CALL   = 3'd4,
        JK_RET    = 3'd5
    } jump_kind_e;

    typedef struct packed {
        jump_kind_e             kind;
        logic [4:0]             jump_type;
        logic [CONST_WIDTH-1:0] constant;
    } lane_dec_t;

    // Any transfer that always leaves the sequential stream ends the bundle.
    function automatic logic ends_bundle(input jump_kind_e kind);
        return (kind == JK_UNCOND) || (kind == JK_INDIR) ||
               (kind == JK_CALL)   || (kind == JK_RET);
    endfunction

    // Lanes whose target is ip + constant.
    function automatic logic is_direct(input jump_kind_e kind);
        return (kind == JK_COND) || (kind == JK_UNCOND) || (kind == JK_CALL);
    endfunction

endpackage : jump_decode_ras_pkg
`default_nettype wire

// File: rtl/jump_decode_ras_if.sv
`default_nettype none
// ============================================================================
// Module      : jump_decode_ras_if
// Description : Bundle interface between the instruction-queue extract stage,
//               the jump decoder and the branch unit.
//               master = environment side, slave = jump_decode_ras side.
// Signals     : input bundle (in_valid/in_ready, lane valid, instr, magic,
//               ip, ret_ip, lizztruss), output bundle (out_valid/out_ready,
//               lane valid, flags, jump_type, constant, target), RAS status
//               and recovery (ras_empty, commit_push, commit_pop, flush).
// Config      : JDEC_RAS_EN (affects the decoder only)
// Revision    : 1.0 - initial multi-lane release
// ============================================================================
interface jump_decode_ras_if
    import jump_decode_ras_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int IP_WIDTH    = 48,
    parameter int INSTR_WIDTH = 80
);
    // input side
    logic                         lizztruss;
    logic                         in_valid;
    logic                         in_ready;
    logic [LANES-1:0]             in_lane_vld;
    logic [LANES*INSTR_WIDTH-1:0] instr;
    logic [LANES*4-1:0]           magic;
    logic [LANES*IP_WIDTH-1:0]    ip;
    logic [LANES*IP_WIDTH-1:0]    ret_ip;
    // output side
    logic                         out_valid;
    logic                         out_ready;
    logic [LANES-1:0]             out_lane_vld;
    logic [LANES-1:0]             is_jump;
    logic [LANES-1:0]             jump_indir;
    logic [LANES-1:0]             push_call;
    logic [LANES-1:0]             pop_call;
    logic [LANES*5-1:0]           jump_type;
    logic [LANES*CONST_WIDTH-1:0] constant;
    logic [LANES*IP_WIDTH-1:0]    target;
    // RAS status / recovery
    logic                         ras_empty;
    logic                         commit_push;
    logic                         commit_pop;
    logic                         flush;

    modport master (
        output lizztruss, in_valid, in_lane_vld, instr, magic, ip, ret_ip,
               out_ready, commit_push, commit_pop, flush,
        input  in_ready, out_valid, out_lane_vld, is_jump, jump_indir,
               push_call, pop_call, jump_type, constant, target, ras_empty
    );

    modport slave (
        input  lizztruss, in_valid, in_lane_vld, instr, magic, ip, ret_ip,
               out_ready, commit_push, commit_pop, flush,
        output in_ready, out_valid, out_lane_vld, is_jump, jump_indir,
               push_call, pop_call, jump_type, constant, target, ras_empty
    );

endinterface : jump_decode_ras_if
`default_nettype wire

// File: rtl/jump_decode_ras_lane.sv
`default_nettype none
// ============================================================================
// Module      : jdec_lane
// Description : Purely combinational decode of one instruction lane into a
//               jump kind, jump_type and sign-extended, doubled displacement.
// Ports       : instr     - lane instruction (opcode in [7:0])
//               magic     - length/format code; bit 0 enables decode
//               lizztruss - inverts the conditional polarity bit
//               dec       - decode result (lane_dec_t)
// Config      : none (identical in every build)
// Revision    : 1.0 - initial multi-lane release
// ============================================================================
module jdec_lane
    import jump_decode_ras_pkg::*;
#(
    parameter int INSTR_WIDTH = 80
) (
    input  wire logic [INSTR_WIDTH-1:0] instr,
    input  wire logic [3:0]             magic,
    input  wire logic                   lizztruss,
    output lane_dec_t                   dec
);

    logic [7:0] w_opc;
    logic [2:0] w_sub;
    logic       w_unused;

    assign w_opc = instr[7:0];
    assign w_sub = instr[15:13];

    // Bits no format uses.
    assign w_unused = ^{instr[INSTR_WIDTH-1:48], instr[32], magic[3]};

    always_comb begin
        dec = '{kind: JK_NONE, jump_type: 5'h00, constant: '0};
        if (magic[0]) begin
            if (w_opc[7:4] == c_OPC_COND_HI) begin
                dec.kind      = JK_COND;
                dec.jump_type = {1'b0, w_opc[3:1], w_opc[0] ^ lizztruss};
                // Short form checked first: magic 3'b011 has magic[1:0]=11,
                // so the two encodings never overlap.
                if (magic[1:0] == 2'b01) begin
                    dec.constant = {{51{instr[31]}}, instr[31:19], 1'b0};
                end else if (magic[2:0] == 3'b011) begin
                    dec.constant = {{49{instr[47]}}, instr[47:33], 1'b0};
                end
            end else if (w_opc == c_OPC_UNCOND) begin
                dec.kind      = JK_UNCOND;
                dec.jump_type = JT_UNCOND;
                if (magic[1:0] == 2'b01) begin
                    dec.constant = {{40{instr[31]}}, instr[31:8], 1'b0};
                end
            end else if (w_opc == c_OPC_GROUP) begin
                case (w_sub)
                    c_SUB_INDIR: begin
                        dec.kind      = JK_INDIR;
                        dec.jump_type = JT_INDIR;
                    end
                    c_SUB_CALL_A, c_SUB_CALL_B: begin
                        dec.kind      = JK_CALL;
                        dec.jump_type = JT_UNCOND;
                        dec.constant  = {{48{instr[31]}}, instr[31:16], 1'b0};
                    end
                    c_SUB_RET: begin
                        dec.kind      = JK_RET;
                        dec.jump_type = JT_INDIR;
                    end
                    default: ; // unassigned sub-ops decode as non-jumps
                endcase
            end
        end
    end

endmodule : jdec_lane
`default_nettype wire

// File: rtl/jump_decode_ras.sv
`default_nettype none
// ============================================================================
// Module      : jump_decode_ras
// Description : Pipelined multi-lane jump decoder. Decodes up to LANES
//               instructions per cycle, computes direct targets, truncates the
//               bundle after the first unconditional transfer and predicts
//               return targets from a speculative return-address stack.
// Ports       : clk, rst (asynchronous, active-high)
//               bus (jump_decode_ras_if.slave) - input bundle, registered
//               output bundle, ras_empty, commit_push/commit_pop, flush
// Config      : JDEC_RAS_EN - when defined, the RAS array and speculative /
//               committed pointers are built; otherwise return targets are 0,
//               ras_empty is tied 1 and commit_* are ignored.
// Revision    : 1.0 - initial multi-lane release
// ============================================================================
module jump_decode_ras
    import jump_decode_ras_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int RAS_DEPTH   = 8,
    parameter int IP_WIDTH    = 48,
    parameter int INSTR_WIDTH = 80
) (
    input  wire logic         clk,
    input  wire logic         rst,
    jump_decode_ras_if.slave  bus
);

    // ------------------------------------------------------------------
    // Lane decode
    // ------------------------------------------------------------------
    lane_dec_t w_dec [LANES];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        jdec_lane #(
            .INSTR_WIDTH (INSTR_WIDTH)
        ) u_jdec_lane (
            .instr     (bus.instr[gi*INSTR_WIDTH +: INSTR_WIDTH]),
            .magic     (bus.magic[gi*4 +: 4]),
            .lizztruss (bus.lizztruss),
            .dec       (w_dec[gi])
        );
    end

    // ------------------------------------------------------------------
    // Truncation: lanes up to and including the first valid bundle-ending
    // transfer survive. Invalid lanes never stop the scan.
    // ------------------------------------------------------------------
    logic [LANES-1:0] w_keep;
    logic             w_stop;

    always_comb begin
        w_keep = '0;
        w_stop = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (bus.in_lane_vld[i] && !w_stop) begin
                w_keep[i] = 1'b1;
                if (ends_bundle(w_dec[i].kind)) begin
                    w_stop = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_out_valid;
    logic w_in_ready;
    logic w_accept;

    assign w_in_ready = ~r_out_valid | bus.out_ready;
    // flush wins: the bundle presented in a flush cycle is dropped.
    assign w_accept   = bus.in_valid & w_in_ready & ~bus.flush;

    // ------------------------------------------------------------------
    // Return-address stack
    // ------------------------------------------------------------------
    logic [IP_WIDTH-1:0] w_ras_top;
    logic                w_ras_empty;

`ifdef JDEC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] c_PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [IP_WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]    r_spec_ptr, w_spec_ptr_nxt;
    logic [CNT_W-1:0]    r_spec_cnt, w_spec_cnt_nxt;
    logic [PTR_W-1:0]    r_cmt_ptr,  w_cmt_ptr_nxt;
    logic [CNT_W-1:0]    r_cmt_cnt,  w_cmt_cnt_nxt;
    logic [PTR_W-1:0]    w_push_ptr;
    logic                w_do_push;
    logic                w_do_pop;
    logic [IP_WIDTH-1:0] w_push_data;

    // Truncation guarantees at most one surviving call or return.
    always_comb begin
        w_do_push   = 1'b0;
        w_do_pop    = 1'b0;
        w_push_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_keep[i] && (w_dec[i].kind == JK_CALL)) begin
                w_do_push   = 1'b1;
                w_push_data = bus.ret_ip[i*IP_WIDTH +: IP_WIDTH];
            end
            if (w_keep[i] && (w_dec[i].kind == JK_RET)) begin
                w_do_pop = 1'b1;
            end
        end
    end

    assign w_push_ptr  = r_spec_ptr + c_PTR_ONE;
    assign w_ras_empty = (r_spec_cnt == '0);
    assign w_ras_top   = w_ras_empty ? '0 : r_ras[r_spec_ptr];

    // Committed pair: a simultaneous push and pop cancel out.
    always_comb begin
        w_cmt_ptr_nxt = r_cmt_ptr;
        w_cmt_cnt_nxt = r_cmt_cnt;
        if (bus.commit_push && !bus.commit_pop) begin
            w_cmt_ptr_nxt = r_cmt_ptr + c_PTR_ONE;
            if (r_cmt_cnt != c_CNT_FULL) begin
                w_cmt_cnt_nxt = r_cmt_cnt + c_CNT_ONE;
            end
        end else if (bus.commit_pop && !bus.commit_push && (r_cmt_cnt != '0)) begin
            w_cmt_ptr_nxt = r_cmt_ptr - c_PTR_ONE;
            w_cmt_cnt_nxt = r_cmt_cnt - c_CNT_ONE;
        end
    end

    // Speculative pair: on flush it takes the committed state including this
    // cycle's commit update. A pop on an empty stack is a no-op.
    always_comb begin
        w_spec_ptr_nxt = r_spec_ptr;
        w_spec_cnt_nxt = r_spec_cnt;
        if (bus.flush) begin
            w_spec_ptr_nxt = w_cmt_ptr_nxt;
            w_spec_cnt_nxt = w_cmt_cnt_nxt;
        end else if (w_accept && w_do_push) begin
            w_spec_ptr_nxt = w_push_ptr;
            if (r_spec_cnt != c_CNT_FULL) begin
                w_spec_cnt_nxt = r_spec_cnt + c_CNT_ONE;
            end
        end else if (w_accept && w_do_pop && !w_ras_empty) begin
            w_spec_ptr_nxt = r_spec_ptr - c_PTR_ONE;
            w_spec_cnt_nxt = r_spec_cnt - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_spec_ptr <= '0;
            r_spec_cnt <= '0;
            r_cmt_ptr  <= '0;
            r_cmt_cnt  <= '0;
        end else begin
            r_spec_ptr <= w_spec_ptr_nxt;
            r_spec_cnt <= w_spec_cnt_nxt;
            r_cmt_ptr  <= w_cmt_ptr_nxt;
            r_cmt_cnt  <= w_cmt_cnt_nxt;
        end
    end

    // Entry storage carries no reset; validity is tracked by the counts.
    // A push when full lands on the oldest slot because the pointer wraps.
    always_ff @(posedge clk) begin
        if (w_accept && w_do_push) begin
            r_ras[w_push_ptr] <= w_push_data;
        end
    end
`else
    logic w_unused_cfg;

    assign w_ras_top    = '0;
    assign w_ras_empty  = 1'b1;
    assign w_unused_cfg = ^{bus.ret_ip, bus.commit_push, bus.commit_pop, 32'(RAS_DEPTH)};
`endif

    // ------------------------------------------------------------------
    // Next output bundle; lanes removed by truncation are zeroed entirely.
    // ------------------------------------------------------------------
    logic [LANES-1:0]             w_is_jump;
    logic [LANES-1:0]             w_indir;
    logic [LANES-1:0]             w_push;
    logic [LANES-1:0]             w_pop;
    logic [LANES*5-1:0]           w_jtype;
    logic [LANES*CONST_WIDTH-1:0] w_const;
    logic [LANES*IP_WIDTH-1:0]    w_target;

    always_comb begin
        w_is_jump = '0;
        w_indir   = '0;
        w_push    = '0;
        w_pop     = '0;
        w_jtype   = '0;
        w_const   = '0;
        w_target  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_keep[i]) begin
                w_is_jump[i] = (w_dec[i].kind != JK_NONE);
                w_indir[i]   = (w_dec[i].kind == JK_INDIR);
                w_push[i]    = (w_dec[i].kind == JK_CALL);
                w_pop[i]     = (w_dec[i].kind == JK_RET);
                w_jtype[i*5 +: 5]                   = w_dec[i].jump_type;
                w_const[i*CONST_WIDTH +: CONST_WIDTH] = w_dec[i].constant;
                if (is_direct(w_dec[i].kind)) begin
                    w_target[i*IP_WIDTH +: IP_WIDTH] =
                        bus.ip[i*IP_WIDTH +: IP_WIDTH] + w_dec[i].constant[IP_WIDTH-1:0];
                end else if (w_dec[i].kind == JK_RET) begin
                    // Reads the stack as it stood before this bundle's update.
                    w_target[i*IP_WIDTH +: IP_WIDTH] = w_ras_top;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic [LANES-1:0]             r_lane_vld;
    logic [LANES-1:0]             r_is_jump;
    logic [LANES-1:0]             r_indir;
    logic [LANES-1:0]             r_push;
    logic [LANES-1:0]             r_pop;
    logic [LANES*5-1:0]           r_jtype;
    logic [LANES*CONST_WIDTH-1:0] r_const;
    logic [LANES*IP_WIDTH-1:0]    r_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_lane_vld  <= '0;
            r_is_jump   <= '0;
            r_indir     <= '0;
            r_push      <= '0;
            r_pop       <= '0;
            r_jtype     <= '0;
            r_const     <= '0;
            r_target    <= '0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_in_ready) begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_lane_vld <= w_keep;
                r_is_jump  <= w_is_jump;
                r_indir    <= w_indir;
                r_push     <= w_push;
                r_pop      <= w_pop;
                r_jtype    <= w_jtype;
                r_const    <= w_const;
                r_target   <= w_target;
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_lane_vld = r_lane_vld;
    assign bus.is_jump      = r_is_jump;
    assign bus.jump_indir   = r_indir;
    assign bus.push_call    = r_push;
    assign bus.pop_call     = r_pop;
    assign bus.jump_type    = r_jtype;
    assign bus.constant     = r_const;
    assign bus.target       = r_target;
    assign bus.ras_empty    = w_ras_empty;

endmodule : jump_decode_ras
`default_nettype wire

// File: tb/tb_jump_decode_ras.sv
`default_nettype none
// ============================================================================
// Module      : tb_jump_decode_ras
// Description : Directed self-checking bench for jump_decode_ras (LANES=2,
//               RAS_DEPTH=8). Expected RAS results follow JDEC_RAS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jump_decode_ras;
    import jump_decode_ras_pkg::*;

    localparam int LANES = 2;
    localparam int DEPTH = 8;
    localparam int IPW   = 48;
    localparam int IW    = 80;
`ifdef JDEC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    jump_decode_ras_if #(.LANES(LANES), .IP_WIDTH(IPW), .INSTR_WIDTH(IW)) bus ();

    jump_decode_ras #(
        .LANES(LANES), .RAS_DEPTH(DEPTH), .IP_WIDTH(IPW), .INSTR_WIDTH(IW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- instruction builders ----------------
    function automatic logic [IW-1:0] f_cond(input logic [7:0] opc, input logic [12:0] d);
        logic [IW-1:0] v = '0;
        v[7:0] = opc; v[31:19] = d;
        return v;
    endfunction
    function automatic logic [IW-1:0] f_cond_long(input logic [7:0] opc, input logic [14:0] d);
        logic [IW-1:0] v = '0;
        v[7:0] = opc; v[47:33] = d;
        return v;
    endfunction
    function automatic logic [IW-1:0] f_uncond(input logic [23:0] d);
        logic [IW-1:0] v = '0;
        v[7:0] = 8'd181; v[31:8] = d;
        return v;
    endfunction
    function automatic logic [IW-1:0] f_grp(input logic [2:0] sub, input logic [15:0] d);
        logic [IW-1:0] v = '0;
        v[7:0] = 8'd182; v[15:13] = sub; v[31:16] = d;
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.lizztruss   = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_lane_vld = '0;
        bus.instr       = '0;
        bus.magic       = '0;
        bus.ip          = '0;
        bus.ret_ip      = '0;
        bus.out_ready   = 1'b1;
        bus.commit_push = 1'b0;
        bus.commit_pop  = 1'b0;
        bus.flush       = 1'b0;
    endtask

    task automatic set_lane(input int l, input logic [IW-1:0] ins, input logic [3:0] mg,
                            input logic [IPW-1:0] ipv, input logic [IPW-1:0] rip);
        bus.instr[l*IW +: IW]    = ins;
        bus.magic[l*4 +: 4]      = mg;
        bus.ip[l*IPW +: IPW]     = ipv;
        bus.ret_ip[l*IPW +: IPW] = rip;
        bus.in_lane_vld[l]       = 1'b1;
        bus.in_valid             = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) tick();
        if (bus.out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); n_err++; end
        n_vec++;
        if (bus.out_lane_vld !== 2'b00) begin $display("FAIL reset_lane_vld: got %b want 00", bus.out_lane_vld); n_err++; end
        n_vec++;
        if (bus.target !== '0) begin $display("FAIL reset_target: got %h want 0", bus.target); n_err++; end
        n_vec++;
        if (bus.constant !== '0) begin $display("FAIL reset_constant: got %h want 0", bus.constant); n_err++; end
        n_vec++;
        if (bus.ras_empty !== 1'b1) begin $display("FAIL reset_ras_empty: got %b want 1", bus.ras_empty); n_err++; end
        n_vec++;
        if (bus.in_ready !== 1'b1) begin $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); n_err++; end
        n_vec++;
        rst = 1'b0;
    endtask

    task automatic test_decode();
        // conditional, short displacement -1 -> constant -2
        clear_inputs();
        set_lane(0, f_cond(8'hA4, 13'h1FFF), 4'b0001, 48'h1000, 48'h1004);
        #1;
        if (bus.out_valid !== 1'b0) begin $display("FAIL cond_latency: got %b want 0", bus.out_valid); n_err++; end
        n_vec++;
        tick();
        if (bus.out_valid !== 1'b1) begin $display("FAIL cond_out_valid: got %b want 1", bus.out_valid); n_err++; end
        n_vec++;
        if (bus.out_lane_vld !== 2'b01) begin $display("FAIL cond_lane_vld: got %b want 01", bus.out_lane_vld); n_err++; end
        n_vec++;
        if (bus.is_jump !== 2'b01) begin $display("FAIL cond_is_jump: got %b want 01", bus.is_jump); n_err++; end
        n_vec++;
        if (bus.jump_type[4:0] !== 5'h04) begin $display("FAIL cond_type: got %h want 04", bus.jump_type[4:0]); n_err++; end
        n_vec++;
        if (bus.constant[64:0] !== 65'h1_FFFF_FFFF_FFFF_FFFE) begin $display("FAIL cond_const: got %h want 1fffffffffffffffe", bus.constant[64:0]); n_err++; end
        n_vec++;
        if (bus.target[47:0] !== 48'h0FFE) begin $display("FAIL cond_target: got %h want 0ffe", bus.target[47:0]); n_err++; end
        n_vec++;

        // conditional, long form, polarity inverted; lane1 undecoded (magic[0]=0)
        clear_inputs();
        bus.lizztruss = 1'b1;
        set_lane(0, f_cond_long(8'hA4, 15'h0010), 4'b0011, 48'h2000, 48'h2006);
        set_lane(1, f_cond(8'hA4, 13'h0001), 4'b0000, 48'h2006, 48'h200A);
        tick();
        if (bus.jump_type[4:0] !== 5'h05) begin $display("FAIL cond_lizz_type: got %h want 05", bus.jump_type[4:0]); n_err++; end
        n_vec++;
        if (bus.constant[64:0] !== 65'h20) begin $display("FAIL cond_long_const: got %h want 20", bus.constant[64:0]); n_err++; end
        n_vec++;
        if (bus.target[47:0] !== 48'h2020) begin $display("FAIL cond_long_target: got %h want 2020", bus.target[47:0]); n_err++; end
        n_vec++;
        if (bus.out_lane_vld !== 2'b11 || bus.is_jump !== 2'b01) begin $display("FAIL nonjump_lane: got vld %b jmp %b want 11 01", bus.out_lane_vld, bus.is_jump); n_err++; end
        n_vec++;
        if (bus.target[95:48] !== 48'h0 || bus.jump_type[9:5] !== 5'h0) begin $display("FAIL nonjump_data: got %h/%h want 0/0", bus.target[95:48], bus.jump_type[9:5]); n_err++; end
        n_vec++;

        // unconditional truncates the following conditional
        clear_inputs();
        set_lane(0, f_uncond(24'h000100), 4'b0001, 48'h4000, 48'h4005);
        set_lane(1, f_cond(8'hA2, 13'h0004), 4'b0001, 48'h4005, 48'h4009);
        tick();
        if (bus.out_lane_vld !== 2'b01) begin $display("FAIL uncond_trunc: got %b want 01", bus.out_lane_vld); n_err++; end
        n_vec++;
        if (bus.jump_type[4:0] !== 5'h10) begin $display("FAIL uncond_type: got %h want 10", bus.jump_type[4:0]); n_err++; end
        n_vec++;
        if (bus.target[47:0] !== 48'h4200) begin $display("FAIL uncond_target: got %h want 4200", bus.target[47:0]); n_err++; end
        n_vec++;

        // invalid lane0 does not truncate; lane1 indirect
        clear_inputs();
        set_lane(0, f_uncond(24'h000100), 4'b0001, 48'h5000, 48'h5005);
        bus.in_lane_vld[0] = 1'b0;
        set_lane(1, f_grp(3'd0, 16'h0000), 4'b0001, 48'h5005, 48'h5008);
        tick();
        if (bus.out_lane_vld !== 2'b10 || bus.jump_indir !== 2'b10) begin $display("FAIL indir_flags: got vld %b ind %b want 10 10", bus.out_lane_vld, bus.jump_indir); n_err++; end
        n_vec++;
        if (bus.jump_type[9:5] !== 5'h11 || bus.target[95:48] !== 48'h0) begin $display("FAIL indir_data: got %h/%h want 11/0", bus.jump_type[9:5], bus.target[95:48]); n_err++; end
        n_vec++;
        clear_inputs();
        tick();
    endtask

    task automatic test_call_ret();
        do_reset();
        if (bus.ras_empty !== 1'b1) begin $display("FAIL call_empty_before: got %b want 1", bus.ras_empty); n_err++; end
        n_vec++;
        set_lane(0, f_grp(3'd1, 16'h0008), 4'b0001, 48'h2000, 48'h2004);
        set_lane(1, f_cond(8'hA0, 13'h0002), 4'b0001, 48'h2004, 48'h2008);
        tick();
        if (bus.out_lane_vld !== 2'b01 || bus.push_call !== 2'b01) begin $display("FAIL call_flags: got vld %b push %b want 01 01", bus.out_lane_vld, bus.push_call); n_err++; end
        n_vec++;
        if (bus.target[47:0] !== 48'h2010) begin $display("FAIL call_target: got %h want 2010", bus.target[47:0]); n_err++; end
        n_vec++;
        if (bus.ras_empty !== !RAS_ON) begin $display("FAIL call_empty_after: got %b want %b", bus.ras_empty, !RAS_ON); n_err++; end
        n_vec++;
        clear_inputs();
        set_lane(0, f_grp(3'd3, 16'h0000), 4'b0001, 48'h3000, 48'h3004);
        tick();
        if (bus.pop_call !== 2'b01 || bus.jump_type[4:0] !== 5'h11) begin $display("FAIL ret_flags: got pop %b type %h want 01 11", bus.pop_call, bus.jump_type[4:0]); n_err++; end
        n_vec++;
        if (bus.target[47:0] !== (RAS_ON ? 48'h2004 : 48'h0)) begin $display("FAIL ret_target: got %h want %h", bus.target[47:0], (RAS_ON ? 48'h2004 : 48'h0)); n_err++; end
        n_vec++;
        if (bus.ras_empty !== 1'b1) begin $display("FAIL ret_empty_after: got %b want 1", bus.ras_empty); n_err++; end
        n_vec++;
        clear_inputs();
        tick();
    endtask

    task automatic test_ras_overflow();
        logic [IPW-1:0] exp_t;
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            clear_inputs();
            set_lane(0, f_grp(3'd2, 16'h0000), 4'b0001, 48'h8000, IPW'(k * 'h100));
            tick();
        end
        for (int j = 1; j <= 9; j++) begin
            clear_inputs();
            set_lane(0, f_grp(3'd3, 16'h0000), 4'b0001, 48'h9000, 48'h9004);
            tick();
            exp_t = (RAS_ON && j <= 8) ? IPW'((10 - j) * 'h100) : '0;
            if (bus.target[47:0] !== exp_t) begin $display("FAIL ovf_ret%0d: got %h want %h", j, bus.target[47:0], exp_t); n_err++; end
            n_vec++;
        end
        if (bus.ras_empty !== 1'b1) begin $display("FAIL ovf_empty: got %b want 1", bus.ras_empty); n_err++; end
        n_vec++;
        clear_inputs();
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            clear_inputs();
            set_lane(0, f_grp(3'd1, 16'h0000), 4'b0001, 48'h7000, IPW'('hA0 + k * 'h10));
            tick();
        end
        // commit the first push and flush in the same cycle; the call is dropped
        clear_inputs();
        set_lane(0, f_grp(3'd1, 16'h0000), 4'b0001, 48'h7000, 48'hEE);
        bus.commit_push = 1'b1;
        bus.flush       = 1'b1;
        tick();
        if (bus.out_valid !== 1'b0) begin $display("FAIL flush_out_valid: got %b want 0", bus.out_valid); n_err++; end
        n_vec++;
        if (bus.ras_empty !== !RAS_ON) begin $display("FAIL flush_empty: got %b want %b", bus.ras_empty, !RAS_ON); n_err++; end
        n_vec++;
        clear_inputs();
        set_lane(0, f_grp(3'd3, 16'h0000), 4'b0001, 48'h7100, 48'h7104);
        tick();
        if (bus.target[47:0] !== (RAS_ON ? 48'hA0 : 48'h0)) begin $display("FAIL flush_ret_target: got %h want %h", bus.target[47:0], (RAS_ON ? 48'hA0 : 48'h0)); n_err++; end
        n_vec++;
        if (bus.ras_empty !== 1'b1) begin $display("FAIL flush_ret_empty: got %b want 1", bus.ras_empty); n_err++; end
        n_vec++;
        clear_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.out_ready = 1'b0;
        set_lane(0, f_grp(3'd1, 16'h0004), 4'b0001, 48'h600, 48'h500);
        tick();
        if (bus.out_valid !== 1'b1 || bus.target[47:0] !== 48'h608) begin $display("FAIL bp_first: got v %b t %h want 1 608", bus.out_valid, bus.target[47:0]); n_err++; end
        n_vec++;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.in_ready !== 1'b0) begin $display("FAIL bp_in_ready%0d: got %b want 0", c, bus.in_ready); n_err++; end
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.target[47:0] !== 48'h608 || bus.push_call !== 2'b01) begin $display("FAIL bp_hold%0d: got v %b t %h p %b want 1 608 01", c, bus.out_valid, bus.target[47:0], bus.push_call); n_err++; end
            n_vec++;
        end
        clear_inputs();
        tick();
        if (bus.out_valid !== 1'b0) begin $display("FAIL bp_drain: got %b want 0", bus.out_valid); n_err++; end
        n_vec++;
        set_lane(0, f_grp(3'd3, 16'h0000), 4'b0001, 48'h900, 48'h904);
        tick();
        if (bus.target[47:0] !== (RAS_ON ? 48'h500 : 48'h0)) begin $display("FAIL bp_ret_target: got %h want %h", bus.target[47:0], (RAS_ON ? 48'h500 : 48'h0)); n_err++; end
        n_vec++;
        if (bus.ras_empty !== 1'b1) begin $display("FAIL bp_single_push: got %b want 1", bus.ras_empty); n_err++; end
        n_vec++;
        clear_inputs();
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        set_lane(0, f_grp(3'd1, 16'h0000), 4'b0001, 48'hA00, 48'h900);
        tick();
        if (bus.out_valid !== 1'b1 || bus.ras_empty !== !RAS_ON) begin $display("FAIL arst_pre: got v %b e %b want 1 %b", bus.out_valid, bus.ras_empty, !RAS_ON); n_err++; end
        n_vec++;
        #2 rst = 1'b1;
        #1;
        if (bus.out_valid !== 1'b0 || bus.out_lane_vld !== 2'b00) begin $display("FAIL arst_out: got v %b l %b want 0 00", bus.out_valid, bus.out_lane_vld); n_err++; end
        n_vec++;
        if (bus.ras_empty !== 1'b1 || bus.target !== '0) begin $display("FAIL arst_state: got e %b t %h want 1 0", bus.ras_empty, bus.target); n_err++; end
        n_vec++;
        rst = 1'b0;
        clear_inputs();
        set_lane(0, f_grp(3'd3, 16'h0000), 4'b0001, 48'hB00, 48'hB04);
        tick();
        if (bus.out_valid !== 1'b1 || bus.target[47:0] !== 48'h0) begin $display("FAIL arst_ret_empty: got v %b t %h want 1 0", bus.out_valid, bus.target[47:0]); n_err++; end
        n_vec++;
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_call_ret();
        test_ras_overflow();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_jump_decode_ras
`default_nettype wire

// File: doc/jump_decode_ras.md
# jump_decode_ras

- Pipelined, multi-lane successor to the single-instruction jump decoder; sits between the instruction-queue extract stage and the branch unit.
- Decodes up to LANES instructions per cycle, computes direct targets, and truncates the bundle after the first unconditional control transfer.
- Predicts return targets from a speculative return-address stack (RAS) with commit/flush recovery.

## Interface
Parameters:
- LANES, 2, instructions decoded per cycle (1..4)
- RAS_DEPTH, 8, RAS entries (power of two)
- IP_WIDTH, 48, instruction-pointer width
- INSTR_WIDTH, 80, per-lane instruction width

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset, asynchronous, active-high
- lizztruss  in  1  inverts conditional-jump polarity bit
- in_valid  in  1  bundle valid
- in_ready  out  1  bundle accepted when in_valid & in_ready
- in_lane_vld  in  LANES  per-lane valid mask
- instr  in  LANES*INSTR_WIDTH  lane i at [i*INSTR_WIDTH +: INSTR_WIDTH]
- magic  in  LANES*4  per-lane length/format code
- ip  in  LANES*IP_WIDTH  lane instruction address
- ret_ip  in  LANES*IP_WIDTH  address of next sequential instruction
- out_valid  out  1  registered bundle valid
- out_ready  in  1  downstream accepts
- out_lane_vld  out  LANES  lanes surviving truncation
- is_jump, jump_indir, push_call, pop_call  out  LANES each  per-lane flags
- jump_type  out  LANES*5  per-lane type
- constant  out  LANES*65  sign-extended displacement
- target  out  LANES*IP_WIDTH  predicted target
- ras_empty  out  1  speculative RAS holds no entries
- commit_push, commit_pop  in  1  retired call/ret
- flush  in  1  pipeline flush

## Operation
Decode applies only when magic[0]=1; otherwise the lane is a non-jump. opc = instr[7:0].

| Instruction | Decode | jump_type | constant / flags |
|---|---|---|---|
| Conditional | opc[7:4]=4'b1010 | {1'b0, opc[3:1], opc[0]^lizztruss} | magic[1:0]=01: sext(instr[31:19])<<1; magic[2:0]=011: sext(instr[47:33])<<1 |
| Unconditional | opc=181 | 5'h10 | magic[1:0]=01: sext(instr[31:8])<<1 |
| Indirect | opc=182, instr[15:13]=0 | 5'h11 | jump_indir=1 |
| Call | opc=182, instr[15:13]=1 or 2 | 5'h10 | sext(instr[31:16])<<1; push_call=1 |
| Return | opc=182, instr[15:13]=3 | 5'h11 | pop_call=1 |

- Constant in all other jump cases: 0.
- Non-jump lanes: all flags 0, jump_type 0, constant 0, target 0.
- Targets:
  - Direct: ip+constant, truncated to IP_WIDTH.
  - Return: RAS top, or 0 if empty.
  - Indirect: 0.
- Truncation: the lowest valid lane that is unconditional, indirect, call or return clears out_lane_vld for all higher lanes. This gives at most one RAS operation per bundle.
- Speculative RAS:
  - Circular array; pointer spec_ptr plus a count saturating at RAS_DEPTH.
  - Push writes ret_ip of the call lane at spec_ptr+1 and advances.
  - Pop reads the top and retreats; a pop when empty leaves the state unchanged and sets target=0.
  - A push when full overwrites the oldest entry and wraps the pointer.
- Committed pointer/count: commit_push and commit_pop update a second pointer/count by the same rules. Both asserted together: net zero.
- flush copies the committed pointer/count into the speculative pair and drops the output register (out_valid=0). Entries overwritten by wrong-path pushes are not restored.

## Timing
- Latency 1: a bundle accepted at edge N appears on the outputs after edge N.
- in_ready = ~out_valid | out_ready. The output register holds stable while out_valid & ~out_ready.
- RAS speculative update occurs on acceptance. The RAS read for a return uses the state before that cycle's update.
- flush has priority over acceptance in the same cycle: the input bundle is discarded and in_ready is ignored. commit_* in the flush cycle is applied before the copy.
- Reset: out_valid=0, out_lane_vld=0, all output flags/data 0, both pointers 0, counts 0, ras_empty=1. Array contents are don't-care.
- Reset asserted mid-bundle discards it immediately and asynchronously.

## Configuration
JDEC_RAS_EN:
- Defined: RAS logic as above.
- Undefined: no array or pointers; return target=0; ras_empty tied 1; commit_*/flush affect only the output register.
- Decode and truncation are identical in both builds.

## Structure
- Shared package: jump_type encodings (JT_UNCOND=5'h10, JT_INDIR=5'h11), opcode constants (181, 182), and the lane-decode result struct.
- Sub-module jdec_lane: purely combinational single-lane decode, instantiated LANES times. The top level holds truncation, the registers and the RAS.

## Test plan
- Lane0 opc=8'hA4, magic=4'b0001, instr[31:19]=13'h1FFF, ip=0x1000 → cond, jump_type=5'h04, constant=-2, target=0x0FFE, latency 1.
- Lane0 call (182, sub 1, ret_ip=0x2004), next bundle lane0 ret → lane1 of the first bundle cleared; return target=0x2004; ras_empty 1→0→1.
- Nine calls with RAS_DEPTH=8, then eight returns → oldest entry lost; ninth return hits empty: target=0, no pointer underflow.
- Three speculative pushes, one commit_push, then flush → ras_empty=0; next return predicts the first pushed address.
- out_ready=0 for 3 cycles with in_valid held → outputs stable, in_ready=0, no double RAS push.
- Assert rst mid-transfer → out_valid=0 asynchronously and ras_empty=1; with JDEC_RAS_EN undefined, return target=0.
